// File: rtl/pe16.sv
// pe16: one binary16 multiply-accumulate per clock, sum_out <= sum_in + floatA*floatB.
// Build option PE16_SUBNORMAL_EN enables gradual underflow; the default build flushes subnormals to zero.
module pe16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  input  logic [15:0] sum_in,
  output logic [15:0] sum_out
);

  localparam logic [15:0] QNAN = 16'h7E00;

  // Split a binary16 word into sign, 11-bit significand and the unbiased
  // exponent of the significand LSB (value = sig * 2^e_lsb).
  function automatic void unpack(
    input  logic [15:0] x,
    output logic        s,
    output logic [10:0] sig,
    output int          e_lsb,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero
  );
    s      = x[15];
    is_nan = (x[14:10] == 5'h1f) && (x[9:0] != 10'd0);
    is_inf = (x[14:10] == 5'h1f) && (x[9:0] == 10'd0);
    if (x[14:10] == 5'd0) begin
      e_lsb = -24;
`ifdef PE16_SUBNORMAL_EN
      sig = {1'b0, x[9:0]};
`else
      sig = 11'd0;
`endif
    end else begin
      e_lsb = int'(x[14:10]) - 25;
      sig   = {1'b1, x[9:0]};
    end
    is_zero = (sig == 11'd0);
  endfunction

  // Normalise an arbitrary magnitude (value = mag * 2^e_lsb), round to
  // nearest-even at binary16 precision and pack, handling overflow/underflow.
  function automatic logic [15:0] round_pack(
    input logic        sgn,
    input int          e_lsb,
    input logic [31:0] mag
  );
    int          l;
    int          be;
    int          lsb_exp;
    int          t;
    int          field;
    logic [5:0]  tsh;
    logic [63:0] ext;
    logic [11:0] kept;
    logic [11:0] kept_r;
    logic        guard;
    logic        sticky;
    logic [9:0]  frac;
    logic [15:0] res;

    l = 0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) l = i;
    end
    be = e_lsb + l + 15;
`ifdef PE16_SUBNORMAL_EN
    lsb_exp = (be < 1) ? -24 : be - 25;
`else
    lsb_exp = be - 25;
`endif
    // The magnitude sits above 32 zero bits so the right shift that picks the
    // kept significand also exposes guard and sticky.
    t   = lsb_exp - e_lsb + 32;
    ext = {mag, 32'd0};
    tsh = 6'd0;
    if (t > 63) begin
      kept   = 12'd0;
      guard  = 1'b0;
      sticky = (mag != 32'd0);
    end else begin
      tsh    = 6'(t);
      kept   = 12'(ext >> tsh);
      guard  = ext[tsh - 6'd1];
      sticky = |(ext & ((64'd1 << (tsh - 6'd1)) - 64'd1));
    end
    kept_r = kept + {11'd0, guard & (sticky | kept[0])};

    frac  = kept_r[9:0];
    field = be;
    if (kept_r[11]) begin
      frac  = kept_r[10:1];
      field = be + 1;
    end
`ifdef PE16_SUBNORMAL_EN
    else if (be < 1) begin
      field = kept_r[10] ? 1 : 0;
    end
`else
    else begin
      field = be;
    end
`endif

    if (mag == 32'd0)
      res = {sgn, 15'd0};
    else if (field >= 31)
      res = {sgn, 5'h1f, 10'd0};
    else if (field < 1)
`ifdef PE16_SUBNORMAL_EN
      res = {sgn, 5'd0, frac};
`else
      res = {sgn, 15'd0};
`endif
    else
      res = {sgn, 5'(field), frac};
    return res;
  endfunction

  // Product stage: p = round(floatA * floatB).
  logic        sa, sb, ps;
  logic [10:0] sig_a, sig_b;
  int          ea, eb;
  logic        nan_a, inf_a, zero_a;
  logic        nan_b, inf_b, zero_b;
  logic [21:0] prod_mag;
  logic [15:0] prod;

  always_comb begin
    sa = 1'b0; sig_a = 11'd0; ea = 0; nan_a = 1'b0; inf_a = 1'b0; zero_a = 1'b0;
    sb = 1'b0; sig_b = 11'd0; eb = 0; nan_b = 1'b0; inf_b = 1'b0; zero_b = 1'b0;
    unpack(floatA, sa, sig_a, ea, nan_a, inf_a, zero_a);
    unpack(floatB, sb, sig_b, eb, nan_b, inf_b, zero_b);
    prod_mag = 22'(sig_a) * 22'(sig_b);
    ps       = sa ^ sb;
    if (nan_a | nan_b | (inf_a & zero_b) | (zero_a & inf_b))
      prod = QNAN;
    else if (inf_a | inf_b)
      prod = {ps, 5'h1f, 10'd0};
    else if (zero_a | zero_b)
      prod = {ps, 15'd0};
    else
      prod = round_pack(ps, ea + eb, {10'd0, prod_mag});
  end

  // Sum stage: round(p + sum_in) with the larger magnitude as the minuend.
  logic        sp, ss, sx, sy, st;
  logic [10:0] sig_p, sig_s, sigx, sigy;
  int          ep, es, ex, ey, d;
  logic        nan_p, inf_p, zero_p;
  logic        nan_s, inf_s, zero_s;
  logic [13:0] y14, ya;
  logic [14:0] m;
  logic [15:0] sum_next;

  always_comb begin
    sp = 1'b0; sig_p = 11'd0; ep = 0; nan_p = 1'b0; inf_p = 1'b0; zero_p = 1'b0;
    ss = 1'b0; sig_s = 11'd0; es = 0; nan_s = 1'b0; inf_s = 1'b0; zero_s = 1'b0;
    sx = 1'b0; sy = 1'b0; sigx = 11'd0; sigy = 11'd0; ex = 0; ey = 0; d = 0;
    st = 1'b0; y14 = 14'd0; ya = 14'd0; m = 15'd0;
    unpack(prod,   sp, sig_p, ep, nan_p, inf_p, zero_p);
    unpack(sum_in, ss, sig_s, es, nan_s, inf_s, zero_s);

    if (nan_p | nan_s | (inf_p & inf_s & (sp ^ ss)))
      sum_next = QNAN;
    else if (inf_p)
      sum_next = {sp, 5'h1f, 10'd0};
    else if (inf_s)
      sum_next = {ss, 5'h1f, 10'd0};
    else if (zero_p & zero_s)
      sum_next = {sp & ss, 15'd0};
    else begin
      if ((ep > es) || ((ep == es) && (sig_p >= sig_s))) begin
        sx = sp; sigx = sig_p; ex = ep;
        sy = ss; sigy = sig_s; ey = es;
      end else begin
        sx = ss; sigx = sig_s; ex = es;
        sy = sp; sigy = sig_p; ey = ep;
      end
      // Three extra bits act as guard/round/sticky; far-away operands only jam sticky.
      d   = ex - ey;
      y14 = {sigy, 3'b000};
      if (d >= 13) begin
        ya = 14'd0;
        st = (sigy != 11'd0);
      end else begin
        ya = y14 >> 4'(d);
        st = |(y14 & ((14'd1 << 4'(d)) - 14'd1));
      end
      ya[0] = ya[0] | st;
      if (sx == sy)
        m = {1'b0, sigx, 3'b000} + {1'b0, ya};
      else
        m = {1'b0, sigx, 3'b000} - {1'b0, ya};
      if (m == 15'd0)
        sum_next = 16'h0000;
      else
        sum_next = round_pack(sx, ex - 3, {17'd0, m});
    end
  end

  // No handshake: a new MAC is accepted and registered on every clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sum_out <= 16'h0000;
    else
      sum_out <= sum_next;
  end

endmodule

// File: tb/tb_pe16.sv
// Bench for pe16: directed MAC vectors, expected results queued at issue and
// checked by an independent monitor one clock later.
module tb_pe16;

  logic        clk;
  logic        rst_n;
  logic [15:0] floatA;
  logic [15:0] floatB;
  logic [15:0] sum_in;
  logic [15:0] sum_out;

  logic [15:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

`ifdef PE16_SUBNORMAL_EN
  localparam logic [15:0] EXP_SUB_HALF = 16'h0200;
  localparam logic [15:0] EXP_SUB_NEG  = 16'h8200;
  localparam logic [15:0] EXP_SUB_TINY = 16'h0401;
`else
  localparam logic [15:0] EXP_SUB_HALF = 16'h0000;
  localparam logic [15:0] EXP_SUB_NEG  = 16'h8000;
  localparam logic [15:0] EXP_SUB_TINY = 16'h0400;
`endif

  pe16 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .floatA (floatA),
    .floatB (floatB),
    .sum_in (sum_in),
    .sum_out(sum_out)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                          input logic [15:0] exp, input string name);
    floatA = a;
    floatB = b;
    sum_in = s;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [15:0] s,
                       input logic [15:0] exp, input string name);
    @(negedge clk);
    drive_op(a, b, s, exp, name);
  endtask

  // Monitor / scoreboard: a result is due one edge after each issue
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0)
        check(name_q.pop_front(), sum_out, exp_q.pop_front());
    end
  end

  // Stimulus
  initial begin
    rst_n  = 1'b1;
    floatA = 16'($urandom_range(0, 16'hffff));
    floatB = 16'($urandom_range(0, 16'hffff));
    sum_in = 16'($urandom_range(0, 16'hffff));
    #1 rst_n = 1'b0;
    #1 check("rst_async", sum_out, 16'h0000);
    repeat (2) @(posedge clk);
    #1 check("rst_hold", sum_out, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    drive_op(16'h3C00, 16'h4000, 16'h0000, 16'h4000, "one_times_two");

    issue(16'h4200, 16'h4000, 16'h4000, 16'h4800, "acc_3x2");
    issue(16'h3800, 16'h3E00, 16'h3C00, 16'h3F00, "acc_half");
    issue(16'hC000, 16'h4200, 16'h3C00, 16'hC500, "neg_prod");
    issue(16'h4000, 16'h4000, 16'hC400, 16'h0000, "cancel_zero");
    issue(16'h3C01, 16'h3C01, 16'h0000, 16'h3C02, "rne_prod");
    issue(16'h7C00, 16'h0000, 16'h0000, 16'h7E00, "inf_x_zero");
    issue(16'h7BFF, 16'h4000, 16'h0000, 16'h7C00, "prod_overflow");
    issue(16'h7E00, 16'h3C00, 16'h0000, 16'h7E00, "nan_in");
    issue(16'h3C00, 16'h3C00, 16'h7C01, 16'h7E00, "nan_sum");
    issue(16'h7C00, 16'h3C00, 16'hFC00, 16'h7E00, "inf_minus_inf");
    issue(16'h7C00, 16'hC000, 16'h0000, 16'hFC00, "neg_inf");
    issue(16'h8000, 16'h3C00, 16'h8000, 16'h8000, "neg_zeros");
    issue(16'hFBFF, 16'h3C00, 16'hFBFF, 16'hFC00, "sum_overflow");
    issue(16'h3C00, 16'h3C00, 16'h6800, 16'h6800, "tie_even_dn");
    issue(16'h3C00, 16'h3C00, 16'h6801, 16'h6802, "tie_even_up");
    issue(16'h3C00, 16'h1000, 16'h6400, 16'h6400, "sticky_far");
    issue(16'h3C00, 16'h3C00, 16'hBC01, 16'h9400, "lzc_cancel");
    issue(16'h0400, 16'h3800, 16'h0000, EXP_SUB_HALF, "sub_half");
    issue(16'h8400, 16'h3800, 16'h8000, EXP_SUB_NEG, "sub_neg");
    issue(16'h0001, 16'h3C00, 16'h0400, EXP_SUB_TINY, "sub_tiny");

    // Reset in the middle of a stream of non-zero MACs
    issue(16'h4400, 16'h4400, 16'h3C00, 16'h4C40, "pre_rst_a");
    issue(16'h4200, 16'h4200, 16'h0000, 16'h4880, "pre_rst_b");
    issue(16'h3C00, 16'h4500, 16'h0000, 16'h4500, "pre_rst_c");
    #2 rst_n = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1 check("rst_mid_async", sum_out, 16'h0000);
    @(posedge clk);
    #1 check("rst_mid_hold", sum_out, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive_op(16'h4000, 16'h3800, 16'h3C00, 16'h4000, "post_rst_fresh");

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
